// File: rtl/alloc_req_feeder.sv
// Request feeder for the strip allocator: filters illegal sizes, buffers legal
// requests in a FIFO and presents one per 4-cycle allocator slot, tagged in order.
module alloc_req_feeder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 8,
  parameter int unsigned MAX_H = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [4:0]       req_height_i,
  input  logic [4:0]       req_width_i,
  output logic [4:0]       height_o,
  output logic [4:0]       width_o,
  output logic             issue_valid_o,
  output logic [TAG_W-1:0] issue_tag_o,
  output logic             rej_o,
  output logic [7:0]       rej_cnt_o,
  output logic [3:0]       level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [4:0]       h;
    logic [4:0]       w;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic [1:0]       phase;
  logic [TAG_W-1:0] seq;

  logic full, empty, legal, accept, push, pop, load;

  always_comb begin
    full   = (count == LW'(DEPTH));
    empty  = (count == '0);
    legal  = (req_height_i != '0) && (32'(req_height_i) <= MAX_H) && (req_width_i != '0);
    accept = req_valid_i && !full;
    push   = accept && legal;
    // phase tracks the allocator's own counter; pre-edge value 1 marks a load edge
    load   = (phase == 2'd1);
    pop    = load && !empty;
  end

  assign req_ready_o = !full;
  assign level_o     = 4'(count);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= '{tag: seq, h: req_height_i, w: req_width_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      phase         <= 2'd3;
      seq           <= '0;
      height_o      <= '0;
      width_o       <= '0;
      issue_valid_o <= 1'b0;
      issue_tag_o   <= '0;
      rej_o         <= 1'b0;
      rej_cnt_o     <= '0;
    end else begin
      phase <= phase + 2'd1;
      rej_o <= accept && !legal;
      if (accept && !legal && rej_cnt_o != '1) rej_cnt_o <= rej_cnt_o + 8'd1;

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq    <= seq + TAG_W'(1);
      end

      if (load) begin
        if (pop) begin
          height_o      <= mem[rd_ptr].h;
          width_o       <= mem[rd_ptr].w;
          issue_tag_o   <= mem[rd_ptr].tag;
          issue_valid_o <= 1'b1;
          rd_ptr        <= rd_ptr + AW'(1);
        end else begin
          height_o      <= '0;
          width_o       <= '0;
          issue_valid_o <= 1'b0;
        end
      end

      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
